// File: rtl/uart_rx_cfg_if.sv
// Signal bundle between a UART line / consumer and uart_rx_cfg.
// o_Rx_DV is a valid-only strobe (no ready): the consumer must take o_Rx_Byte and the
// error flags in the cycle o_Rx_DV is high; they then hold until the next o_Rx_DV.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Frame_Err;
    logic                 o_Parity_Err;
    logic                 o_Busy;
    logic [2:0]           o_State;

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Busy, o_State
    );

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Busy, o_State
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority voting and break detection.
// Define UART_RX_PARITY_EN to build the parity bit state and parity check.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    uart_rx_cfg_if.slave bus
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_MID     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] C_PRE     = C_MID - CNT_W'(1);
    localparam logic [CNT_W-1:0] C_POST    = C_MID + CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_cfg: parameter out of legal range");
    end

    // Encodings are fixed so the debug state output reads the same in every build.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               r_state, w_next;
    logic                 w_done;
    logic                 r_rx_meta, r_rx_s;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_idx;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr_acc;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_ferr;
    logic                 w_vote, w_at_post, w_at_last, w_new_state;

    assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_at_post   = (r_cnt == C_POST);
    assign w_at_last   = (r_cnt == C_LAST);
    assign w_new_state = (w_next != r_state);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
        end else begin
            r_rx_meta <= bus.i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  if (!r_rx_s) w_next = S_START;
            S_START: begin
                if (w_at_post && w_vote) w_next = S_IDLE;
                else if (w_at_last)      w_next = S_DATA;
            end
            S_DATA: begin
                if (w_at_last && r_idx == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_at_last) w_next = S_STOP;
`endif
            // Leave mid-way through the last stop bit so a following start edge is never missed.
            S_STOP: begin
                if (w_at_post && r_idx == LAST_STOP) begin
                    w_done = 1'b1;
                    w_next = w_vote ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: if (r_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (w_new_state || w_at_last || r_state == S_IDLE || r_state == S_BREAK)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_new_state)
                r_idx <= '0;
            else if (w_at_last && (r_state == S_DATA || r_state == S_STOP))
                r_idx <= r_idx + 4'd1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_ferr_acc <= 1'b0;
        end else begin
            if (r_cnt == C_PRE) r_s0 <= r_rx_s;
            if (r_cnt == C_MID) r_s1 <= r_rx_s;
            if (r_state == S_DATA && w_at_post)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (r_state == S_START)
                r_ferr_acc <= 1'b0;
            else if (r_state == S_STOP && w_at_post && !w_vote)
                r_ferr_acc <= 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_dv   <= 1'b0;
            r_byte <= '0;
            r_ferr <= 1'b0;
        end else begin
            r_dv <= w_done;
            if (w_done) begin
                r_byte <= r_shift;
                r_ferr <= r_ferr_acc | ~w_vote;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_at_post) r_par_bit <= w_vote;
            if (w_done) r_perr <= ((^r_shift) ^ r_par_bit) != (PARITY_ODD != 0);
        end
    end

    assign bus.o_Parity_Err = r_perr;
`else
    assign bus.o_Parity_Err = 1'b0;
`endif

    assign bus.o_Rx_DV     = r_dv;
    assign bus.o_Rx_Byte   = r_byte;
    assign bus.o_Frame_Err = r_ferr;
    assign bus.o_Busy      = (r_state != S_IDLE);
    assign bus.o_State     = r_state;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: serial frame driver plus a scoreboard of expected frames.
module tb_uart_rx_cfg;
    localparam int CPB        = 104;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int W          = DATA_BITS + 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd5;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx_cfg #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DATA_BITS),
        .STOP_BITS   (STOP_BITS),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .bus    (bus.slave)
    );

    int             checks = 0;
    int             errors = 0;
    int             dv_cnt = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // driver tasks (all aligned to the falling clock edge)
    task automatic idle(input int n);
        bus.i_Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        bus.i_Rx_Serial = b;
        if (glitch) begin
            repeat (CPB / 2) @(negedge clk);
            bus.i_Rx_Serial = ~b;
            @(negedge clk);
            bus.i_Rx_Serial = b;
            repeat (CPB - CPB / 2 - 1) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] data, input logic stop_val,
                              input logic par_val, input int glitch_idx);
        logic exp_perr;
        exp_perr = PAR_EN && (((^data) ^ par_val) != (PARITY_ODD != 0));
        exp_q.push_back({exp_perr, ~stop_val, data});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i], i == glitch_idx);
        if (PAR_EN) drive_bit(par_val, 1'b0);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_val, 1'b0);
    endtask

    // scoreboard: every o_Rx_DV pulse consumes one expected frame
    always @(negedge clk) begin
        if (rst_n && bus.o_Rx_DV) begin
            dv_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_dv_queue_size", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_frame", {bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Rx_Byte}, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int             dv0;
        int             n;
        logic [DATA_BITS-1:0] d;
        logic [DATA_BITS-1:0] abort_d;

        bus.i_Rx_Serial = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_dv",    bus.o_Rx_DV, 0);
        check("rst_byte",  bus.o_Rx_Byte, 0);
        check("rst_ferr",  bus.o_Frame_Err, 0);
        check("rst_perr",  bus.o_Parity_Err, 0);
        check("rst_busy",  bus.o_Busy, 0);
        check("rst_state", bus.o_State, ST_IDLE);
        rst_n = 1'b1;
        idle(20);

        // single clean frame
        send_frame(8'h55, 1'b1, good_par(8'h55), -1);
        idle(20);
        check("dv_count_0x55", dv_cnt, 1);
        check("busy_after_0x55", bus.o_Busy, 0);

        // short low glitch on an idle line
        dv0 = dv_cnt;
        bus.i_Rx_Serial = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", bus.o_Busy, 1);
        repeat (10) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        n = 0;
        while (bus.o_Busy && n < CPB) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_low", bus.o_Busy, 0);
        check("glitch_no_dv", dv_cnt, dv0);
        idle(CPB);

        // stop bit low followed by a held-low break
        dv0 = dv_cnt;
        send_frame(8'hA3, 1'b0, good_par(8'hA3), -1);
        repeat (500) @(negedge clk);
        check("break_state", bus.o_State, ST_BREAK);
        check("break_busy", bus.o_Busy, 1);
        check("break_one_dv", dv_cnt, dv0 + 1);
        check("break_byte_held", bus.o_Rx_Byte, 8'hA3);
        check("break_ferr_held", bus.o_Frame_Err, 1);
        idle(10);
        check("break_exit_idle", bus.o_State, ST_IDLE);
        check("break_no_extra_dv", dv_cnt, dv0 + 1);

`ifdef UART_RX_PARITY_EN
        // explicit parity bits, good and bad
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(10);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(10);
`endif

        // random frames, some with a one-cycle glitch inside a data bit
        for (int k = 0; k < 4; k++) begin
            d = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
            send_frame(d, 1'b1, good_par(d), $urandom_range(0, DATA_BITS + 2));
            idle($urandom_range(0, 30));
        end
        idle(20);

        // back-to-back frames with no idle gap
        dv0 = dv_cnt;
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1);
        send_frame(8'hC3, 1'b1, good_par(8'hC3), -1);
        idle(20);
        check("b2b_dv_count", dv_cnt, dv0 + 2);

        // reset during data bit 4 aborts the frame
        dv0 = dv_cnt;
        abort_d = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(abort_d[i], 1'b0);
        bus.i_Rx_Serial = abort_d[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_dv",    bus.o_Rx_DV, 0);
        check("abort_byte",  bus.o_Rx_Byte, 0);
        check("abort_ferr",  bus.o_Frame_Err, 0);
        check("abort_perr",  bus.o_Parity_Err, 0);
        check("abort_busy",  bus.o_Busy, 0);
        check("abort_state", bus.o_State, ST_IDLE);
        @(negedge clk);
        idle(10);
        rst_n = 1'b1;
        idle(10);
        check("abort_no_dv", dv_cnt, dv0);
        send_frame(8'h81, 1'b1, good_par(8'h81), -1);
        idle(20);
        check("after_abort_dv", dv_cnt, dv0 + 1);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, giving clock cycles per serial bit (12 MHz / 115200); legal range 8..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; legal values 1 or 2.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0: 0 means even parity, 1 means odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-005 i_Clock  input  1  single clock; all state changes on its rising edge.
REQ-006 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_Rx_Serial  input  1  asynchronous UART line; idle high.
REQ-008 o_Rx_DV  output  1  one-cycle pulse: frame complete, data and error flags valid.
REQ-009 o_Rx_Byte  output  DATA_BITS  received data, LSB first on line, bit 0 = first data bit.
REQ-010 o_Frame_Err  output  1  a stop bit was sampled low; valid with o_Rx_DV.
REQ-011 o_Parity_Err  output  1  parity mismatch; valid with o_Rx_DV.
REQ-012 o_Busy  output  1  high in every state except IDLE.

Function
REQ-013 i_Rx_Serial SHALL pass through a two-flop synchroniser; all logic uses the synchronised value (rx_s).
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE -> START when rx_s is low; the bit-cycle counter clears to 0 on entry to START, DATA, PARITY and STOP, and increments each cycle up to CLKS_PER_BIT-1.
REQ-016 Each bit value SHALL be the majority of three rx_s samples taken at counts M-1, M, M+1, where M = CLKS_PER_BIT/2 (integer division).
REQ-017 START: if the majority value is high, return to IDLE (glitch rejection, no o_Rx_DV); otherwise -> DATA at count CLKS_PER_BIT-1.
REQ-018 DATA: shift in DATA_BITS bits LSB first, one per bit period; after the last bit -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
REQ-019 PARITY: sample one bit; the error condition is (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-020 STOP: sample STOP_BITS bits; any low stop bit sets the frame error.
REQ-021 At count M+1 of the last stop bit, the block SHALL, on the next cycle, pulse o_Rx_DV for exactly one cycle, update o_Rx_Byte, o_Frame_Err and o_Parity_Err, and go to IDLE, or to BREAK if the last stop bit was low.
REQ-022 BREAK: remain until rx_s is high, then -> IDLE; no further o_Rx_DV is produced.
REQ-023 o_Rx_Byte, o_Frame_Err and o_Parity_Err SHALL hold their values until the next o_Rx_DV.
REQ-024 A frame with errors SHALL still deliver its data with o_Rx_DV.
REQ-025 A start bit arriving immediately after the stop-bit sample point SHALL be accepted; back-to-back frames lose no data.

Reset
REQ-026 While i_Rst_n is low: state = IDLE, counters = 0, synchroniser flops = 1.
REQ-027 While i_Rst_n is low: o_Rx_DV = 0, o_Rx_Byte = 0, o_Frame_Err = 0, o_Parity_Err = 0, o_Busy = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_Rx_DV; after release, the first falling edge starts a new frame.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the PARITY state and parity check SHALL be built; frame = start + DATA_BITS + parity + STOP_BITS.
REQ-030 Without UART_RX_PARITY_EN, no PARITY state SHALL exist, the frame has no parity bit, and o_Parity_Err is tied to 0.

Verification
REQ-031 CLKS_PER_BIT=104, no parity: send 0x55 with 1 stop bit -> exactly one o_Rx_DV pulse, o_Rx_Byte=0x55, both error flags 0.
REQ-032 Low pulse of 20 cycles on idle line -> no o_Rx_DV; o_Busy returns low within 104 cycles.
REQ-033 Send 0xA3 with the stop bit low, then hold the line low for 500 cycles -> one o_Rx_DV with o_Rx_Byte=0xA3 and o_Frame_Err=1; state is BREAK until the line goes high.
REQ-034 UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0 -> o_Parity_Err=1; then send 0x07 with parity bit 1 -> o_Parity_Err=0.
REQ-035 Send 0x3C and 0xC3 back-to-back with zero idle gap -> two o_Rx_DV pulses, bytes 0x3C then 0xC3.
REQ-036 Assert i_Rst_n low during data bit 4 of a frame -> all outputs 0 immediately, no o_Rx_DV; the next frame, 0x81, is received correctly.
